dpwm_duty_scheduler: RTL and testbench
======================================

Name: dpwm_duty_scheduler

Overview:
Controller that sequences the 9-bit counter-based DPWM. It accepts duty commands from the compensator over a valid/ready handshake, clamps them, and ramps them in during soft-start. It drives the DPWM duty input only at period boundaries, so the DPWM never sees a mid-period update. It forces zero duty on fault or disable. It keeps a mirror period counter that is reset with the DPWM and steps in lockstep with it.

Parameters:
CNT_W, 9, DPWM counter width; period = 2^CNT_W clocks
D_MAX, 460, maximum duty code applied (clamp ceiling)
D_MIN, 0, minimum duty code applied in RUN (clamp floor)
SS_STEP, 4, duty increment per soft-start step
SS_FRAMES, 2, PWM periods per soft-start step (>=1)

Ports:
clk  in  1  system clock, shared with the DPWM
rst  in  1  synchronous, active-low reset
enable  in  1  converter enable; level-sensitive
fault  in  1  over-current/over-voltage fault; sampled each clk
cmd_valid  in  1  duty command valid
cmd_duty  in  CNT_W  requested duty code
cmd_ready  out  1  command accept
d_n_input  out  CNT_W  duty code to DPWM comparator (registered)
frame_tick  out  1  high during the last count of each period (count == 2^CNT_W-1)
ss_done  out  1  high in RUN
fault_latched  out  1  high in FAULT
state  out  2  IDLE=0, SOFT_START=1, RUN=2, FAULT=3

Behaviour:
- Reset (rst==0 at clk edge):
  - count=0, state=IDLE.
  - d_n_input=0, cmd_ready=0, ss_done=0, fault_latched=0.
  - target=0, pending empty, frame divider=0.
- Mirror counter: count increments every clk and wraps 2^CNT_W-1 -> 0. frame_tick is a combinational decode of count==max.
- d_n_input changes only on the clk edge where frame_tick=1. The new value is in effect from count 0. Exception: a fault entry clears it on the next edge.
- Clamp function: clamp(x) = min(max(x, D_MIN), D_MAX). It applies to every accepted command.
- Handshake: a command transfers when cmd_valid && cmd_ready.
  - cmd_ready = (state==SOFT_START) || (state==RUN && pending empty).
  - cmd_ready=0 in IDLE and FAULT.
- IDLE:
  - d_n_input=0.
  - enable=1 && fault=0 -> SOFT_START; target=0, divider=0.
- SOFT_START:
  - An accepted command writes target=clamp(cmd_duty) immediately.
  - Divider counts frame_ticks. On the frame_tick that completes SS_FRAMES periods: d_n_input = min(d_n_input+SS_STEP, target). Compute in CNT_W+1 bits so the add cannot wrap.
  - If target <= d_n_input at a step tick: d_n_input=target and the state moves to RUN on that edge.
  - Reaching target by increment -> RUN on the same edge.
- RUN:
  - An accepted command is stored in the pending register (clamped), and cmd_ready drops the next cycle.
  - At frame_tick with pending full: d_n_input=pending and pending is emptied.
  - A command accepted in the same cycle as frame_tick is applied at the next frame_tick, not the current one.
- FAULT:
  - Entered from any state except reset when fault==1.
  - Next edge: d_n_input=0, not waiting for frame_tick. pending, target and divider are cleared.
  - Exit to IDLE only when fault==0 && enable==0. Restart always goes through soft-start.
- enable==0 in SOFT_START or RUN -> IDLE on the next edge: d_n_input=0 immediately, pending cleared.
- Priority on the same edge: rst > fault > enable-low > frame update > command accept.
- Reset mid-operation aborts everything. The mirror counter restarts at 0, so the DPWM must share the same reset to stay aligned.

Decomposition:
- Shared package dpwm_pkg holds:
  - state encoding localparams (IDLE/SOFT_START/RUN/FAULT)
  - DPWM_CNT_W=9
  - default D_MAX/SS_STEP constants
- One natural sub-module: dpwm_frame_counter. It contains the mirror counter and the frame_tick decode, and is reusable by other DPWM-side blocks.

Test Plan:
- Reset, then enable=1, cmd 200 accepted, SS_STEP=4, SS_FRAMES=2 -> d_n_input steps 4, 8, … one step per 1024 clks. It reaches 200 after 50 steps, then state=RUN and ss_done=1.
- RUN at d=200, cmd 300 sent at count=100 -> cmd_ready low next cycle. d_n_input=300 from the next count 0. cmd_ready returns high after the update.
- RUN, cmd 500 and cmd 0 with D_MAX=460 -> applied values are 460 and 0 (clamped), each at its own period boundary.
- Command accepted exactly when count=511 -> d_n_input unchanged for the following period; new value applied one period later.
- RUN at d=300, fault=1 at count=50 -> next edge d_n_input=0 and state=FAULT. fault=0 with enable=1 keeps FAULT. enable=0 -> IDLE. enable=1 -> ramp restarts from 0.
- Mid-ramp (d=40): first drop enable -> d_n_input=0 and IDLE next edge. Separately, assert rst=0 for 1 clk -> all outputs 0 and count=0.

Source files
------------

// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants and state encoding for the DPWM-side blocks.
//   DPWM_CNT_W      DPWM counter width (period = 2^DPWM_CNT_W clocks)
//   DPWM_D_MAX      default duty clamp ceiling
//   DPWM_SS_STEP    default duty increment per soft-start step
//   DPWM_SS_FRAMES  default PWM periods per soft-start step
//   dpwm_state_e    scheduler state encoding (IDLE/SOFT_START/RUN/FAULT)
package dpwm_pkg;

    localparam int DPWM_CNT_W     = 9;
    localparam int DPWM_D_MAX     = 460;
    localparam int DPWM_SS_STEP   = 4;
    localparam int DPWM_SS_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SOFT_START = 2'd1,
        ST_RUN        = 2'd2,
        ST_FAULT      = 2'd3
    } dpwm_state_e;

endpackage

// File: rtl/dpwm_frame_counter.sv
// dpwm_frame_counter: mirror of the DPWM period counter.
// Must share clock and reset with the DPWM so both counters stay aligned.
//   clk_i         system clock
//   rst_i         synchronous active-low reset (count -> 0)
//   frame_tick_o  high during the last count of each period (count == 2^CNT_W-1)
module dpwm_frame_counter #(
    parameter int CNT_W = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic frame_tick_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Free-running; wraps naturally from all-ones to zero.
    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) count_q <= '0;
        else        count_q <= count_d;
    end

    assign frame_tick_o = &count_q;

endmodule

// File: rtl/dpwm_duty_scheduler.sv
// dpwm_duty_scheduler: sequences the duty code fed to a counter-based DPWM.
// Accepts clamped duty commands over valid/ready, ramps them in during
// soft-start, and only changes the DPWM duty at period boundaries (except
// fault/disable, which force zero on the next edge).
//   clk_i, rst_i     clock, synchronous active-low reset
//   enable_i         converter enable (level)
//   fault_i          fault request, sampled every clock
//   cmd_valid_i      duty command valid
//   cmd_duty_i       requested duty code
//   cmd_ready_o      command accept
//   d_n_input_o      registered duty code to the DPWM comparator
//   frame_tick_o     last count of the current PWM period
//   ss_done_o        high in RUN
//   fault_latched_o  high in FAULT
//   state_o          IDLE=0, SOFT_START=1, RUN=2, FAULT=3
module dpwm_duty_scheduler
    import dpwm_pkg::*;
#(
    parameter int CNT_W     = DPWM_CNT_W,
    parameter int D_MAX     = DPWM_D_MAX,
    parameter int D_MIN     = 0,
    parameter int SS_STEP   = DPWM_SS_STEP,
    parameter int SS_FRAMES = DPWM_SS_FRAMES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fault_i,
    input  logic             cmd_valid_i,
    input  logic [CNT_W-1:0] cmd_duty_i,
    output logic             cmd_ready_o,
    output logic [CNT_W-1:0] d_n_input_o,
    output logic             frame_tick_o,
    output logic             ss_done_o,
    output logic             fault_latched_o,
    output logic [1:0]       state_o
);

    localparam int              DIV_W    = (SS_FRAMES > 1) ? $clog2(SS_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SS_FRAMES - 1);

    dpwm_state_e      state_q,    state_d;
    logic [CNT_W-1:0] duty_q,     duty_d;
    logic [CNT_W-1:0] target_q,   target_d;
    logic [CNT_W-1:0] pend_q,     pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] div_q,      div_d;

    logic             frame_tick;
    logic             accept;
    logic [CNT_W:0]   step_sum;

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] x);
        int v;
        v = int'(x);
        if (v < D_MIN) v = D_MIN;
        if (v > D_MAX) v = D_MAX;
        return v[CNT_W-1:0];
    endfunction

    dpwm_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .frame_tick_o (frame_tick)
    );

    // One extra bit so the soft-start increment cannot wrap past full scale.
    assign step_sum = {1'b0, duty_q} + (CNT_W+1)'(SS_STEP);

    // RUN holds a single pending command; ready drops until the boundary
    // consumes it.
    assign cmd_ready_o = (state_q == ST_SOFT_START) ||
                         ((state_q == ST_RUN) && !pend_vld_q);
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        target_d   = target_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        div_d      = div_q;

        if (fault_i) begin
            // Fault bypasses the period boundary: zero duty on the next edge.
            state_d    = ST_FAULT;
            duty_d     = '0;
            target_d   = '0;
            pend_d     = '0;
            pend_vld_d = 1'b0;
            div_d      = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (enable_i) begin
                        state_d  = ST_SOFT_START;
                        target_d = '0;
                        div_d    = '0;
                    end
                end
                ST_SOFT_START, ST_RUN: begin
                    if (!enable_i) begin
                        state_d    = ST_IDLE;
                        duty_d     = '0;
                        target_d   = '0;
                        pend_d     = '0;
                        pend_vld_d = 1'b0;
                        div_d      = '0;
                    end else if (state_q == ST_SOFT_START) begin
                        if (accept) target_d = clamp_duty(cmd_duty_i);
                        // A step uses the target held before this edge.
                        if (frame_tick) begin
                            if (div_q == DIV_LAST) begin
                                div_d = '0;
                                if ((target_q <= duty_q) ||
                                    (step_sum >= {1'b0, target_q})) begin
                                    duty_d  = target_q;
                                    state_d = ST_RUN;
                                end else begin
                                    duty_d = step_sum[CNT_W-1:0];
                                end
                            end else begin
                                div_d = div_q + 1'b1;
                            end
                        end
                    end else begin
                        // Boundary consumes the old pending value; a command
                        // accepted on this same edge waits one more period.
                        if (frame_tick && pend_vld_q) begin
                            duty_d     = pend_q;
                            pend_vld_d = 1'b0;
                        end
                        if (accept) begin
                            pend_d     = clamp_duty(cmd_duty_i);
                            pend_vld_d = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    duty_d = '0;
                    if (!enable_i) state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            target_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            div_q      <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            div_q      <= div_d;
        end
    end

    assign d_n_input_o     = duty_q;
    assign frame_tick_o    = frame_tick;
    assign ss_done_o       = (state_q == ST_RUN);
    assign fault_latched_o = (state_q == ST_FAULT);
    assign state_o         = state_q;

endmodule

// File: tb/tb_dpwm_duty_scheduler.sv
// Self-checking bench for dpwm_duty_scheduler. Expected values come from the
// rules of the block: period position tracked as cycles since reset, ramp as
// min(step*n, target), commands as clamp() applied at the next boundary.
module tb_dpwm_duty_scheduler;

    localparam int PER      = 512;
    localparam int DMAX     = 460;
    localparam int STEP     = 4;
    localparam int FRAMES   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fault;
    logic       cmd_valid;
    logic [8:0] cmd_duty;
    logic       cmd_ready;
    logic [8:0] d_n;
    logic       frame_tick;
    logic       ss_done;
    logic       fault_latched;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cnt  = 0;
    int d_model = 0;

    always #5 clk = ~clk;

    // Position within the PWM period, as implied by the shared reset.
    always @(posedge clk) tb_cnt <= (!rst) ? 0 : (tb_cnt + 1) % PER;

    dpwm_duty_scheduler dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .fault_i         (fault),
        .cmd_valid_i     (cmd_valid),
        .cmd_duty_i      (cmd_duty),
        .cmd_ready_o     (cmd_ready),
        .d_n_input_o     (d_n),
        .frame_tick_o    (frame_tick),
        .ss_done_o       (ss_done),
        .fault_latched_o (fault_latched),
        .state_o         (state)
    );

    function automatic int ref_clamp(input int x);
        return (x > DMAX) ? DMAX : ((x < 0) ? 0 : x);
    endfunction

    function automatic int ramp_exp(input int wraps, input int tgt);
        int v;
        v = STEP * (wraps / FRAMES);
        return (v > tgt) ? tgt : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int t);
        for (int i = 0; i < PER && tb_cnt != t; i++) tick();
    endtask

    task automatic send_one(input int v);
        cmd_valid = 1'b1;
        cmd_duty  = 9'(v);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Ramp check from SOFT_START entry up to `wraps_end` period boundaries.
    task automatic ramp_to(input int tgt, input int wraps_end, input string nm);
        int w;
        w = 0;
        while (w < wraps_end) begin
            wait_cnt(PER - 1);
            n_tests++;
            if (d_n !== 9'(ramp_exp(w, tgt))) begin
                n_fail++;
                $display("FAIL %s_hold w=%0d got=%0d exp=%0d", nm, w, d_n, ramp_exp(w, tgt));
            end
            tick();
            w++;
            n_tests++;
            if (d_n !== 9'(ramp_exp(w, tgt))) begin
                n_fail++;
                $display("FAIL %s_step w=%0d got=%0d exp=%0d", nm, w, d_n, ramp_exp(w, tgt));
            end
            n_tests++;
            if (ramp_exp(w, tgt) < tgt && state !== 2'd1) begin
                n_fail++;
                $display("FAIL %s_state w=%0d got=%0d exp=1", nm, w, state);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; fault = 1'b0; cmd_valid = 1'b1; cmd_duty = 9'd77;
        tick(); tick();
        n_tests++;
        if ({d_n, cmd_ready, ss_done, fault_latched, state, frame_tick} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs d=%0d rdy=%0b ss=%0b fl=%0b st=%0d ft=%0b exp all 0",
                     d_n, cmd_ready, ss_done, fault_latched, state, frame_tick);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_no_ready rdy=%0b st=%0d exp 0/0", cmd_ready, state);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_frame_tick();
        for (int i = 0; i < PER + 4; i++) begin
            n_tests++;
            if (frame_tick !== (tb_cnt == PER - 1)) begin
                n_fail++;
                $display("FAIL frame_tick cnt=%0d got=%0b", tb_cnt, frame_tick);
            end
            tick();
        end
    endtask

    task automatic test_soft_start();
        wait_cnt(5);
        enable = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd1 || cmd_ready !== 1'b1 || d_n !== 9'd0) begin
            n_fail++;
            $display("FAIL ss_entry st=%0d rdy=%0b d=%0d exp 1/1/0", state, cmd_ready, d_n);
        end
        send_one(200);
        ramp_to(200, 100, "ramp200");
        n_tests++;
        if (state !== 2'd2 || ss_done !== 1'b1 || d_n !== 9'd200) begin
            n_fail++;
            $display("FAIL ss_to_run st=%0d ss=%0b d=%0d exp 2/1/200", state, ss_done, d_n);
        end
        d_model = 200;
    endtask

    task automatic test_run_update();
        wait_cnt(100);
        send_one(300);
        n_tests++;
        if (cmd_ready !== 1'b0 || d_n !== 9'(d_model)) begin
            n_fail++;
            $display("FAIL run_pending rdy=%0b d=%0d exp 0/%0d", cmd_ready, d_n, d_model);
        end
        wait_cnt(PER - 1);
        n_tests++;
        if (d_n !== 9'(d_model)) begin
            n_fail++;
            $display("FAIL run_mid_period d=%0d exp %0d", d_n, d_model);
        end
        tick();
        d_model = 300;
        n_tests++;
        if (d_n !== 9'd300 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_apply d=%0d rdy=%0b exp 300/1", d_n, cmd_ready);
        end
    endtask

    task automatic test_clamp();
        int vals [2] = '{500, 0};
        foreach (vals[k]) begin
            wait_cnt(30);
            send_one(vals[k]);
            wait_cnt(PER - 1);
            tick();
            d_model = ref_clamp(vals[k]);
            n_tests++;
            if (d_n !== 9'(d_model)) begin
                n_fail++;
                $display("FAIL clamp in=%0d got=%0d exp=%0d", vals[k], d_n, d_model);
            end
        end
    endtask

    task automatic test_boundary_accept();
        wait_cnt(PER - 1);
        send_one(123);
        n_tests++;
        if (d_n !== 9'(d_model) || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_accept_hold d=%0d rdy=%0b exp %0d/0", d_n, cmd_ready, d_model);
        end
        wait_cnt(PER - 1);
        n_tests++;
        if (d_n !== 9'(d_model)) begin
            n_fail++;
            $display("FAIL edge_accept_period d=%0d exp %0d", d_n, d_model);
        end
        tick();
        d_model = 123;
        n_tests++;
        if (d_n !== 9'd123) begin
            n_fail++;
            $display("FAIL edge_accept_apply d=%0d exp 123", d_n);
        end
    endtask

    task automatic test_random_cmds();
        int v1, v2, off;
        for (int i = 0; i < 8; i++) begin
            v1  = int'($urandom_range(0, 511));
            v2  = int'($urandom_range(0, 511));
            off = (i == 0) ? 510 : ((i == 1) ? 511 : int'($urandom_range(0, 511)));
            wait_cnt(off);
            cmd_valid = 1'b1; cmd_duty = 9'(v1);
            tick();
            n_tests++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_ready i=%0d got=%0b exp=0", i, cmd_ready);
            end
            cmd_duty = 9'(v2);   // must be ignored while pending is full
            tick();
            cmd_valid = 1'b0;
            if (off != 510) begin
                n_tests++;
                if (d_n !== 9'(d_model)) begin
                    n_fail++;
                    $display("FAIL rnd_early i=%0d off=%0d got=%0d exp=%0d", i, off, d_n, d_model);
                end
            end
            wait_cnt(PER - 1);
            tick();
            d_model = ref_clamp(v1);
            n_tests++;
            if (d_n !== 9'(d_model) || cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_apply i=%0d off=%0d in=%0d got=%0d rdy=%0b exp=%0d",
                         i, off, v1, d_n, cmd_ready, d_model);
            end
        end
    endtask

    task automatic test_fault();
        wait_cnt(20);
        send_one(300);
        wait_cnt(PER - 1);
        tick();
        n_tests++;
        if (d_n !== 9'd300) begin
            n_fail++;
            $display("FAIL fault_setup d=%0d exp 300", d_n);
        end
        wait_cnt(50);
        fault = 1'b1;
        tick();
        n_tests++;
        if (d_n !== 9'd0 || state !== 2'd3 || fault_latched !== 1'b1 || cmd_ready !== 1'b0 || ss_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_entry d=%0d st=%0d fl=%0b rdy=%0b ss=%0b exp 0/3/1/0/0",
                     d_n, state, fault_latched, cmd_ready, ss_done);
        end
        fault = 1'b0;
        wait_cnt(PER - 1);
        tick(); tick();
        n_tests++;
        if (state !== 2'd3 || d_n !== 9'd0) begin
            n_fail++;
            $display("FAIL fault_hold st=%0d d=%0d exp 3/0", state, d_n);
        end
        enable = 1'b0;
        tick();
        n_tests++;
        if (state !== 2'd0 || fault_latched !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_exit st=%0d fl=%0b exp 0/0", state, fault_latched);
        end
        // Fault also takes priority from IDLE.
        fault = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd3) begin
            n_fail++;
            $display("FAIL fault_from_idle st=%0d exp 3", state);
        end
        fault = 1'b0;
        tick();
        wait_cnt(20);
        enable = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd1 || d_n !== 9'd0) begin
            n_fail++;
            $display("FAIL restart_ss st=%0d d=%0d exp 1/0", state, d_n);
        end
        send_one(100);
        ramp_to(100, 20, "ramp100");
    endtask

    task automatic test_enable_drop();
        wait_cnt(7);
        n_tests++;
        if (d_n !== 9'd40) begin
            n_fail++;
            $display("FAIL drop_setup d=%0d exp 40", d_n);
        end
        enable = 1'b0;
        tick();
        n_tests++;
        if (d_n !== 9'd0 || state !== 2'd0 || cmd_ready !== 1'b0 || ss_done !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop d=%0d st=%0d rdy=%0b ss=%0b exp 0/0/0/0", d_n, state, cmd_ready, ss_done);
        end
    endtask

    task automatic test_mid_reset();
        wait_cnt(40);
        enable = 1'b1;
        tick();
        send_one(80);
        ramp_to(80, 4, "ramp80");
        wait_cnt(200);
        rst = 1'b0;
        tick();
        n_tests++;
        if ({d_n, cmd_ready, ss_done, fault_latched, state, frame_tick} !== 15'd0) begin
            n_fail++;
            $display("FAIL mid_reset d=%0d rdy=%0b ss=%0b fl=%0b st=%0d ft=%0b exp all 0",
                     d_n, cmd_ready, ss_done, fault_latched, state, frame_tick);
        end
        rst = 1'b1; enable = 1'b0;
        // Counter restarts at 0: the next tick lands PER-1 cycles later.
        for (int i = 0; i < PER - 1; i++) tick();
        n_tests++;
        if (frame_tick !== 1'b1 || tb_cnt != PER - 1) begin
            n_fail++;
            $display("FAIL reset_realign ft=%0b cnt=%0d exp 1/%0d", frame_tick, tb_cnt, PER - 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_tick();
        test_soft_start();
        test_run_update();
        test_clamp();
        test_boundary_accept();
        test_random_cmds();
        test_fault();
        test_enable_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
